// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) with its own control FSM.
// Optional build macro: DIV_EARLY_OUT_EN skips iteration when |dividend| < |divisor|.
module div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_ZERO, S_ON, S_END} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       dvd_q, dvd_d;
    logic [WIDTH-1:0]       dsr_q, dsr_d;
    logic                   negq_q, negq_d;
    logic                   negr_q, negr_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic                   ready_q, ready_d;

    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [WIDTH:0]         trial;
    logic [WIDTH-1:0]       step_rem, step_quo;

    // Applies the signed correction to raw magnitudes: {remainder, quotient}.
    function automatic logic [2*WIDTH-1:0] fixup(input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] r,
                                                 input logic nq,
                                                 input logic nr);
        logic [WIDTH-1:0] qf, rf;
        qf = nq ? (~q + 1'b1) : q;
        rf = nr ? (~r + 1'b1) : r;
        return {rf, qf};
    endfunction

    always_comb begin
        a_mag = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
        b_mag = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;

        // The top bit of trial is the borrow of the shifted trial subtraction.
        trial    = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dsr_q};
        step_rem = trial[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
        step_quo = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        ready_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    negq_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    negr_d = signed_div & opdata1[WIDTH-1];
                    dvd_d  = a_mag;
                    dsr_d  = b_mag;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (opdata2 == '0) begin
                        dvd_d   = '0;
                        state_d = S_ZERO;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (a_mag < b_mag) begin
                        // Quotient is zero; the dividend becomes the remainder.
                        rem_d   = a_mag;
                        dvd_d   = '0;
                        state_d = S_ZERO;
                    end
`endif
                    else begin
                        state_d = S_ON;
                    end
                end
            end
            S_ZERO: begin
                state_d  = S_END;
                result_d = fixup(dvd_q, rem_q, negq_q, negr_q);
                ready_d  = 1'b1;
            end
            S_ON: begin
                rem_d = step_rem;
                dvd_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = S_END;
                    result_d = fixup(step_quo, step_rem, negq_q, negr_q);
                    ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (annul && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            result_d = result_q;
            ready_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // A flush arriving during END suppresses the result handshake at once.
    assign ready  = ready_q & ~annul;
    assign result = result_q;
    assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: vector table plus hand-written
// annul / reset / back-to-back sequences, scoreboard queue of expected results.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] exp;
        int          lat;
    } sb_t;

    sb_t  sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        return (s && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
        if (mag(a, s) < mag(b, s)) return 2;
`endif
        return 33;
    endfunction

    // Called at a negedge while the DUT is idle; that cycle is cycle 0.
    // Returns at the negedge of the IDLE cycle following END.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input string name);
        sb_t item;
        bit  got;
        sb.push_back('{exp: exp, lat: exp_latency(a, b, s)});
        opdata1    = a;
        opdata2    = b;
        signed_div = s;
        start      = 1'b1;
        got        = 1'b0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) chk({name, " busy"}, {63'd0, busy}, 64'd1);
            if (ready) begin
                got  = 1'b1;
                item = sb.pop_front();
                chk({name, " result"}, result, item.exp);
                chk({name, " latency"}, 64'(c), 64'(item.lat));
                start = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk({name, " ready_pulse"}, {63'd0, ready}, 64'd0);
            end
        end
        if (!got) begin
            item = sb.pop_front();
            chk({name, " timeout"}, 64'd0, 64'd1);
            start = 1'b0;
            repeat (40) @(negedge clk);
        end
    endtask

    vec_t vecs[12];

    initial begin
        logic [63:0] prev;
        bit          seen;

        vecs[0]  = '{32'd100,       32'd7,          1'b0, {32'd2,          32'd14}};
        vecs[1]  = '{32'hFFFFFFF9,  32'd2,          1'b1, {32'hFFFFFFFF,   32'hFFFFFFFD}};
        vecs[2]  = '{32'h80000000,  32'hFFFFFFFF,   1'b1, {32'd0,          32'h80000000}};
        vecs[3]  = '{32'd1234,      32'd0,          1'b0, 64'd0};
        vecs[4]  = '{32'hFFFFFFFF,  32'd1,          1'b0, {32'd0,          32'hFFFFFFFF}};
        vecs[5]  = '{32'd7,         32'hFFFFFFFE,   1'b1, {32'd1,          32'hFFFFFFFD}};
        vecs[6]  = '{32'hFFFFFFF8,  32'hFFFFFFFD,   1'b1, {32'hFFFFFFFE,   32'd2}};
        vecs[7]  = '{32'd3,         32'd10,         1'b0, {32'd3,          32'd0}};
        vecs[8]  = '{32'hFFFFFFF9,  32'd2,          1'b0, {32'd1,          32'h7FFFFFFC}};
        vecs[9]  = '{32'hFFFFFFFB,  32'd0,          1'b1, 64'd0};
        vecs[10] = '{32'hFFFFFFFD,  32'd10,         1'b1, {32'hFFFFFFFD,   32'd0}};
        vecs[11] = '{32'd5,         32'd5,          1'b0, {32'd0,          32'd1}};

        resetn = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0;
        opdata1 = '0; opdata2 = '0;
        #3;
        chk("reset ready", {63'd0, ready}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset result", result, 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Table vectors run back-to-back: each starts in the IDLE cycle after END.
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));

        // start with annul in IDLE must not launch an operation.
        opdata1 = 32'd9; opdata2 = 32'd3; start = 1'b1; annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("annul_idle busy", {63'd0, busy}, 64'd0);
        start = 1'b0; annul = 1'b0;
        @(negedge clk);

        // Annul at cycle 15, new 5/5 start in cycle 16.
        prev = result;
        seen = 1'b0;
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        chk("annul_mid busy", {63'd0, busy}, 64'd0);
        chk("annul_mid ready_seen", {63'd0, (seen | ready)}, 64'd0);
        chk("annul_mid result", result, prev);
        run_op(32'd5, 32'd5, 1'b0, {32'd0, 32'd1}, "after_annul");

        // Annul during END drops ready immediately.
        opdata1 = 32'd42; opdata2 = 32'd6; signed_div = 1'b0; start = 1'b1;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        chk("annul_end reached", {63'd0, seen}, 64'd1);
        annul = 1'b1;
        start = 1'b0;
        #1;
        chk("annul_end ready", {63'd0, ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        chk("annul_end busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset in the middle of ON.
        opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 resetn = 1'b0;
        #1;
        chk("async_reset ready", {63'd0, ready}, 64'd0);
        chk("async_reset busy", {63'd0, busy}, 64'd0);
        chk("async_reset result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
